// File: rtl/signal_activity_pkg.sv
// Shared types and constants for signal_activity_monitor: FSM state enum and
// toggle-count width/saturation value.
package signal_activity_pkg;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  localparam int TOGGLE_CNT_W = 16;
  localparam logic [TOGGLE_CNT_W-1:0] TOGGLE_CNT_MAX = {TOGGLE_CNT_W{1'b1}};
endpackage

// File: rtl/sam_popcount.sv
// Combinational population count of a W-bit vector.
module sam_popcount #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(vec_i[i]);
  end
endmodule

// File: rtl/signal_activity_monitor.sv
// Watches NUM_SIGS signals over a programmed window and reports never-toggled ones.
// Optional saturating toggle total built when SIGNAL_ACTIVITY_MON_TOGGLE_CNT_EN is defined.
module signal_activity_monitor
  import signal_activity_pkg::*;
#(
  parameter int NUM_SIGS = 8,
  parameter int WINDOW_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WINDOW_W-1:0]     window_len,
  input  logic [NUM_SIGS-1:0]     sig_in,
  output logic                    busy,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [NUM_SIGS-1:0]     rpt_stuck_mask,
  output logic [NUM_SIGS-1:0]     rpt_stuck_val,
  output logic [TOGGLE_CNT_W-1:0] rpt_toggle_tot
);
  state_e                  state_q, state_d;
  logic [WINDOW_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SIGS-1:0]     prev_q, prev_d;
  logic [NUM_SIGS-1:0]     tog_q, tog_d;
  logic                    vld_q, vld_d;
  logic [NUM_SIGS-1:0]     mask_q, mask_d;
  logic [NUM_SIGS-1:0]     val_q, val_d;
  logic [TOGGLE_CNT_W-1:0] tot_q, tot_d;
  logic [NUM_SIGS-1:0]     diff;
  logic                    start_ok;
  logic [TOGGLE_CNT_W-1:0] acc_next;

  assign diff     = sig_in ^ prev_q;
  assign start_ok = (state_q == S_IDLE) && start && (window_len != '0);

`ifdef SIGNAL_ACTIVITY_MON_TOGGLE_CNT_EN
  localparam int PCW = $clog2(NUM_SIGS + 1);
  logic [PCW-1:0]          pop;
  logic [TOGGLE_CNT_W:0]   sum;
  logic [TOGGLE_CNT_W-1:0] acc_q;

  sam_popcount #(.W(NUM_SIGS)) u_pop (.vec_i(diff), .cnt_o(pop));

  // Extra carry bit detects overflow so the total sticks at all-ones.
  assign sum      = {1'b0, acc_q} + (TOGGLE_CNT_W + 1)'(pop);
  assign acc_next = sum[TOGGLE_CNT_W] ? TOGGLE_CNT_MAX : sum[TOGGLE_CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || start_ok)         acc_q <= '0;
    else if (state_q == S_RUN)   acc_q <= acc_next;
  end
`else
  assign acc_next = '0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    tog_d   = tog_q;
    vld_d   = vld_q;
    mask_d  = mask_q;
    val_d   = val_q;
    tot_d   = tot_q;
    unique case (state_q)
      S_IDLE: if (start_ok) begin
        state_d = S_RUN;
        cnt_d   = window_len;
        prev_d  = sig_in;
        tog_d   = '0;
      end
      S_RUN: if (abort) begin
        state_d = S_IDLE;
      end else begin
        tog_d  = tog_q | diff;
        prev_d = sig_in;
        cnt_d  = cnt_q - WINDOW_W'(1);
        // Final sample: fold this cycle's toggles straight into the report.
        if (cnt_q == WINDOW_W'(1)) begin
          state_d = S_REPORT;
          vld_d   = 1'b1;
          mask_d  = ~(tog_q | diff);
          val_d   = sig_in;
          tot_d   = acc_next;
        end
      end
      S_REPORT: if (rpt_ready) begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prev_q  <= '0;
      tog_q   <= '0;
      vld_q   <= 1'b0;
      mask_q  <= '0;
      val_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      tog_q   <= tog_d;
      vld_q   <= vld_d;
      mask_q  <= mask_d;
      val_q   <= val_d;
      tot_q   <= tot_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign rpt_valid      = vld_q;
  assign rpt_stuck_mask = mask_q;
  assign rpt_stuck_val  = val_q;
  assign rpt_toggle_tot = tot_q;
endmodule

// File: tb/tb_signal_activity_monitor.sv
// Self-checking bench for signal_activity_monitor: directed table, corner sequences,
// and randomized windows against an array-based reference model.
module tb_signal_activity_monitor;
`ifdef SIGNAL_ACTIVITY_MON_TOGGLE_CNT_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, abort, rpt_ready;
  logic [15:0] window_len;
  logic [7:0]  sig_in;
  logic        busy, rpt_valid;
  logic [7:0]  rpt_stuck_mask, rpt_stuck_val;
  logic [15:0] rpt_toggle_tot;

  int checks   = 0;
  int failures = 0;
  logic [7:0] samp[$];

  always #5 clk = ~clk;

  signal_activity_monitor #(.NUM_SIGS(8), .WINDOW_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .window_len(window_len),
    .sig_in(sig_in), .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_stuck_mask(rpt_stuck_mask), .rpt_stuck_val(rpt_stuck_val),
    .rpt_toggle_tot(rpt_toggle_tot)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: a bit is stuck iff every sample in the window equals the first one.
  function automatic logic [7:0] m_mask();
    logic [7:0] m = 8'hFF;
    for (int k = 1; k < samp.size(); k++) m &= ~(samp[k] ^ samp[0]);
    return m;
  endfunction

  function automatic logic [15:0] m_tot();
    int s = 0;
    if (!TOG_EN) return 16'h0;
    for (int k = 1; k < samp.size(); k++) s += $countones(samp[k] ^ samp[k-1]);
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  // samp[0] is driven on the start cycle, samp[1..n] on the n RUN cycles.
  task automatic run_window(input string nm, input int n, input int abort_at, input int rdy_dly,
                            input bit hs, input bit noise,
                            input logic [7:0] emask, input logic [7:0] eval, input logic [15:0] etot);
    start = 1'b1; window_len = 16'(n); sig_in = samp[0];
    tick();
    start = 1'b0;
    chk({nm, ".busy_run"}, busy, 1);
    for (int k = 1; k <= n; k++) begin
      chk({nm, ".vld_early"}, rpt_valid, 0);
      sig_in = samp[k];
      if (noise) begin
        start = 1'($urandom);
        window_len = 16'($urandom_range(0, 7));
      end
      if (k == abort_at) abort = 1'b1;
      tick();
      abort = 1'b0; start = 1'b0;
      if (k == abort_at) begin
        chk({nm, ".abort_busy"}, busy, 0);
        chk({nm, ".abort_vld"}, rpt_valid, 0);
        repeat (3) begin
          tick();
          chk({nm, ".abort_novld"}, rpt_valid, 0);
        end
        return;
      end
    end
    chk({nm, ".vld"}, rpt_valid, 1);
    chk({nm, ".mask"}, rpt_stuck_mask, emask);
    chk({nm, ".val"}, rpt_stuck_val, eval);
    chk({nm, ".tot"}, rpt_toggle_tot, etot);
    for (int d = 0; d < rdy_dly; d++) begin
      rpt_ready = 1'b0;
      sig_in = 8'($urandom);
      tick();
      chk({nm, ".hold_vld"}, rpt_valid, 1);
      chk({nm, ".hold_mask"}, rpt_stuck_mask, emask);
      chk({nm, ".hold_val"}, rpt_stuck_val, eval);
      chk({nm, ".hold_tot"}, rpt_toggle_tot, etot);
    end
    if (!hs) return;
    // A start in the handshake cycle must not be taken.
    rpt_ready = 1'b1; start = 1'b1; window_len = 16'd5;
    tick();
    rpt_ready = 1'b0; start = 1'b0;
    chk({nm, ".hs_vld"}, rpt_valid, 0);
    chk({nm, ".hs_busy"}, busy, 0);
    chk({nm, ".hs_keep_mask"}, rpt_stuck_mask, emask);
  endtask

  task automatic fill(input int n, input logic [7:0] init, input logic [7:0] tog);
    samp.delete();
    for (int k = 0; k <= n; k++) samp.push_back((k % 2) ? (init ^ tog) : init);
  endtask

  typedef struct {
    int         n;
    logic [7:0] init;
    logic [7:0] tog;
    int         rdy;
    logic [7:0] emask;
    logic [7:0] eval;
    logic [15:0] etot;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{4, 8'hA4, 8'h01, 0, 8'hFE, 8'hA4, 16'd4};
    tbl[1] = '{1, 8'h3C, 8'h81, 1, 8'h7E, 8'hBD, 16'd2};
    tbl[2] = '{3, 8'hFF, 8'h00, 5, 8'hFF, 8'hFF, 16'd0};
    tbl[3] = '{2, 8'h00, 8'hF0, 2, 8'h0F, 8'h00, 16'd8};

    rst = 1'b1; start = 1'b0; abort = 1'b0; rpt_ready = 1'b0;
    window_len = '0; sig_in = '0;
    tick(); tick();
    chk("rst.busy", busy, 0);
    chk("rst.vld", rpt_valid, 0);
    chk("rst.mask", rpt_stuck_mask, 0);
    chk("rst.val", rpt_stuck_val, 0);
    chk("rst.tot", rpt_toggle_tot, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      fill(tbl[i].n, tbl[i].init, tbl[i].tog);
      run_window($sformatf("tbl%0d", i), tbl[i].n, 0, tbl[i].rdy, 1'b1, 1'b0,
                 tbl[i].emask, tbl[i].eval, TOG_EN ? tbl[i].etot : 16'h0);
    end

    // Zero-length start is ignored; abort in IDLE is ignored.
    start = 1'b1; window_len = 16'd0; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("zero.busy", busy, 0);
    repeat (3) begin
      tick();
      chk("zero.vld", rpt_valid, 0);
    end

    // Abort at T+2 of a 10-sample window, then a fresh window runs normally.
    fill(10, 8'h55, 8'hFF);
    run_window("abort2", 10, 2, 0, 1'b1, 1'b0, 8'h00, 8'h55, 16'h0);
    fill(3, 8'h12, 8'h02);
    run_window("after_abort", 3, 0, 0, 1'b1, 1'b0, 8'hFD, 8'h10, TOG_EN ? 16'd3 : 16'd0);

    // Abort on the final sample wins over the report transition.
    fill(2, 8'h00, 8'h01);
    run_window("abort_last", 2, 2, 0, 1'b1, 1'b0, 8'h00, 8'h00, 16'h0);

    // Reset while a report is pending drops it.
    fill(2, 8'hC3, 8'h0F);
    run_window("pre_rst", 2, 0, 1, 1'b0, 1'b0, 8'hF0, 8'hC3, TOG_EN ? 16'd8 : 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.vld", rpt_valid, 0);
    chk("midrst.busy", busy, 0);
    chk("midrst.mask", rpt_stuck_mask, 0);
    chk("midrst.val", rpt_stuck_val, 0);
    chk("midrst.tot", rpt_toggle_tot, 0);
    fill(1, 8'h80, 8'h00);
    run_window("post_rst", 1, 0, 0, 1'b1, 1'b0, 8'hFF, 8'h80, 16'h0);

    // Long window with every bit toggling each cycle: total saturates.
    fill(10000, 8'h00, 8'hFF);
    run_window("long", 10000, 0, 0, 1'b1, 1'b0, 8'h00, 8'h00, TOG_EN ? 16'hFFFF : 16'h0);

    // Randomized windows: some bits held, random aborts, start noise, backpressure.
    for (int r = 0; r < 40; r++) begin
      int n, ab, dly;
      logic [7:0] keep;
      n    = $urandom_range(1, 20);
      ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n) : 0;
      dly  = $urandom_range(0, 4);
      keep = 8'($urandom);
      samp.delete();
      samp.push_back(8'($urandom));
      for (int k = 1; k <= n; k++)
        samp.push_back((samp[k-1] & keep) | (8'($urandom) & ~keep));
      run_window($sformatf("rnd%0d", r), n, ab, dly, 1'b1, 1'b1,
                 m_mask(), samp[n], m_tot());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
